register_bank_module: RTL and testbench

- General-purpose register file for the MIPS pipeline; sink of the write-back stage's result and source of operands for decode.
- Two combinational read ports (rs, rt) and one synchronous write port fed by the write-back mux output and the MEM/WB destination register.
- Debug dump sequencer streams all registers, in address order, to the debug unit over a valid/ready handshake.

---
 rtl/register_bank_module.sv | 140 ++++++++++++++
 tb/tb_register_bank_module.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_module.sv
// rtl/register_bank_module.sv - MIPS GPR file with two read ports, one write port and a debug dump sequencer.
// Optional write-through read bypass: define REGBANK_BYPASS_EN.
module register_bank_module #(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_BITS-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rs_addr,
    output logic [NB_BITS-1:0] o_rs_data,
    input  logic [NB_ADDR-1:0] i_rt_addr,
    output logic [NB_BITS-1:0] o_rt_data,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_BITS-1:0] o_dump_data,
    output logic               o_dump_busy,
    output logic               o_dump_done
);

    localparam int N_REGS = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    logic [NB_BITS-1:0] regs_q [N_REGS];
    logic [NB_BITS-1:0] regs_d [N_REGS];

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] idx_q, idx_d;
    logic [NB_BITS-1:0] dump_data_q, dump_data_d;
    logic [NB_ADDR-1:0] next_idx;

    logic               wr_hit;

    assign wr_hit = i_wr_en && (i_wr_addr != '0);

    // Entry 0 is forced to zero every cycle so it never holds anything else.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[i_wr_addr] = i_wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        o_rs_data = regs_q[i_rs_addr];
        o_rt_data = regs_q[i_rt_addr];
`ifdef REGBANK_BYPASS_EN
        // wr_hit already excludes address 0, so r0 still reads as zero.
        if (wr_hit && (i_wr_addr == i_rs_addr)) begin
            o_rs_data = i_wr_data;
        end
        if (wr_hit && (i_wr_addr == i_rt_addr)) begin
            o_rt_data = i_wr_data;
        end
`endif
        if (i_rs_addr == '0) begin
            o_rs_data = '0;
        end
        if (i_rt_addr == '0) begin
            o_rt_data = '0;
        end
    end

    assign next_idx = idx_q + NB_ADDR'(1);

    // Dump words are captured from stored state only, never from the write port.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dump_data_d  = dump_data_q;
        o_dump_valid = 1'b0;
        o_dump_busy  = 1'b1;
        o_dump_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_dump_busy = 1'b0;
                if (i_dump_start) begin
                    state_d     = ST_SEND;
                    idx_d       = '0;
                    dump_data_d = regs_q[0];
                end
            end
            ST_SEND: begin
                o_dump_valid = 1'b1;
                if (i_dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d       = next_idx;
                        dump_data_d = regs_q[next_idx];
                    end
                end
            end
            ST_DONE: begin
                o_dump_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign o_dump_addr = idx_q;
    assign o_dump_data = dump_data_q;

endmodule

// File: tb/tb_register_bank_module.sv
// tb/tb_register_bank_module.sv - randomized and directed bench for register_bank_module against a behavioural model.
module tb_register_bank_module;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic [4:0]  rt_addr;
    logic [31:0] rt_data;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    register_bank_module #(.NB_BITS(32), .NB_ADDR(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_rs_addr    (rs_addr),
        .o_rs_data    (rs_data),
        .i_rt_addr    (rt_addr),
        .o_rt_data    (rt_data),
        .i_dump_start (dump_start),
        .i_dump_ready (dump_ready),
        .o_dump_valid (dump_valid),
        .o_dump_addr  (dump_addr),
        .o_dump_data  (dump_data),
        .o_dump_busy  (dump_busy),
        .o_dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: register contents plus the dump as "which word, which value, in progress or finishing".
    logic [31:0] m_mem [32];
    int          m_phase;     // 0 idle, 1 presenting words, 2 finishing
    int          m_idx;
    logic [31:0] m_data;
    int          exp_accept;
    int          n_accept;
    int          n_done_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGBANK_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_phase = 0;
        m_idx   = 0;
        m_data  = 32'h0;
    endtask

    task automatic model_step();
        case (m_phase)
            0: if (dump_start) begin
                m_phase    = 1;
                m_idx      = 0;
                m_data     = m_mem[0];
                exp_accept = 0;
            end
            1: if (dump_ready) begin
                if (m_idx == 31) m_phase = 2;
                else begin
                    m_idx  = m_idx + 1;
                    m_data = m_mem[m_idx];
                end
            end
            default: m_phase = 0;
        endcase
        if (wr_en && wr_addr != 5'd0) m_mem[wr_addr] = wr_data;
    endtask

    // One clock: inputs already driven; check at the falling edge, advance model at the rising edge.
    task automatic cycle();
        if (!rst_n) model_reset();
        @(negedge clk);
        check("rs_data", rs_data, exp_read(rs_addr));
        check("rt_data", rt_data, exp_read(rt_addr));
        check("dump_valid", {31'b0, dump_valid}, {31'b0, m_phase == 1});
        check("dump_busy", {31'b0, dump_busy}, {31'b0, m_phase != 0});
        check("dump_done", {31'b0, dump_done}, {31'b0, m_phase == 2});
        if (m_phase == 1) begin
            check("dump_addr", {27'b0, dump_addr}, m_idx);
            check("dump_data", dump_data, m_data);
        end else if (!rst_n) begin
            check("rst_dump_addr", {27'b0, dump_addr}, 32'h0);
            check("rst_dump_data", dump_data, 32'h0);
        end
        if (dump_done) n_done_obs++;
        if (rst_n && dump_valid && dump_ready) begin
            check("accept_order", {27'b0, dump_addr}, exp_accept);
            exp_accept = (exp_accept + 1) % 32;
            n_accept++;
        end
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    int          done_before;
    int          acc_before;
    logic [31:0] or_data;

    initial begin
        exp_accept = 0; n_accept = 0; n_done_obs = 0;
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // r0 stays zero
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        cycle();
        wr_en = 1'b0; #1;
        check("r0_zero", rs_data, 32'h0);
        cycle();

        // write then read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; rs_addr = 5'd5; rt_addr = 5'd5;
        cycle();
        wr_en = 1'b0; #1;
        check("r5_rs", rs_data, 32'h12345678);
        check("r5_rt", rt_data, 32'h12345678);

        // same-cycle read of a register being written
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D; rs_addr = 5'd9; #1;
`ifdef REGBANK_BYPASS_EN
        check("byp_same", rs_data, 32'hCAFEF00D);
`else
        check("byp_same", rs_data, 32'h0);
`endif
        cycle();
        wr_en = 1'b0; #1;
        check("byp_next", rs_data, 32'hCAFEF00D);

        // full dump with ready held high
        for (int n = 1; n < 32; n++) begin
            wr_en = 1'b1; wr_addr = 5'(n); wr_data = 32'(n) * 32'h11; rs_addr = 5'(n); rt_addr = 5'(n - 1);
            cycle();
        end
        idle_inputs();
        done_before = n_done_obs; acc_before = n_accept;
        dump_ready = 1'b1; dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int k = 0; k < 34; k++) cycle();
        check("full_beats", n_accept - acc_before, 32);
        check("full_done_cnt", n_done_obs - done_before, 1);
        check("full_idle", {31'b0, dump_busy}, 32'h0);

        // backpressure 1,0,0,1 with a write to r3 while beat 3 stalls and a stray start
        done_before = n_done_obs; acc_before = n_accept;
        dump_start = 1'b1; dump_ready = 1'b0;
        cycle();
        dump_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            dump_ready = (k % 4 == 0) || (k % 4 == 3);
            dump_start = (k == 7);
            wr_en = 1'b0;
            if (m_phase == 1 && m_idx == 3 && !dump_ready) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000AAAA; #1;
                check("bp_beat3_valid", {31'b0, dump_valid}, 32'h1);
                check("bp_beat3_data", dump_data, 32'h33);
            end
            cycle();
            if (m_phase == 0) break;
        end
        idle_inputs();
        cycle();
        check("bp_idle", {31'b0, dump_busy}, 32'h0);
        check("bp_beats", n_accept - acc_before, 32);
        check("bp_done_cnt", n_done_obs - done_before, 1);

        // abort by reset at beat 10
        dump_ready = 1'b1; dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int k = 0; k < 20 && m_idx < 10; k++) cycle();
        done_before = n_done_obs;
        rst_n = 1'b0; #1;
        check("abort_valid", {31'b0, dump_valid}, 32'h0);
        check("abort_busy", {31'b0, dump_busy}, 32'h0);
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("abort_no_done", n_done_obs - done_before, 0);
        acc_before = n_accept; or_data = 32'h0;
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int k = 0; k < 150; k++) begin
            dump_ready = 1'($urandom_range(0, 1));
            if (dump_valid) or_data = or_data | dump_data;
            cycle();
            if (m_phase == 0) break;
        end
        check("redump_beats", n_accept - acc_before, 32);
        check("redump_zero", or_data, 32'h0);

        // random traffic with overlapping dumps and occasional resets
        for (int k = 0; k < 800; k++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            rs_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rt_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            dump_ready = 1'($urandom_range(0, 1));
            dump_start = ($urandom_range(0, 15) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
